regfile_6809: RTL and testbench

REGFILE_6809 -- requirements
Module: regfile_6809

---
 rtl/regfile_6809.sv | 132 +++++++++++++
 tb/tb_regfile_6809.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_6809.sv
// regfile_6809: 6809 register file with dual read ports, write/index/PC/exchange/CC update paths and NMI arming
module regfile_6809 (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [3:0]  rda_sel,
    input  logic [3:0]  rdb_sel,
    output logic [15:0] rda_out,
    output logic [15:0] rdb_out,
    input  logic        wr_en,
    input  logic [3:0]  wr_sel,
    input  logic [15:0] wr_data,
    input  logic        ccr_we,
    input  logic [7:0]  ccr_in,
    input  logic        idx_en,
    input  logic [1:0]  idx_sel,
    input  logic [1:0]  idx_op,
    input  logic        pc_inc,
    input  logic        pc_ld,
    input  logic [15:0] pc_in,
    input  logic        exg_en,
    input  logic [3:0]  exg_r0,
    input  logic [3:0]  exg_r1,
    output logic [7:0]  cc_out,
    output logic [7:0]  dp_out,
    output logic [15:0] pc_out,
    output logic [15:0] s_out,
    output logic        nmi_armed
);
    logic [7:0]  a_q, a_d, b_q, b_d, cc_q, cc_d, dp_q, dp_d;
    logic [15:0] x_q, x_d, y_q, y_d, u_q, u_d, s_q, s_d, pc_q, pc_d;
    logic        nmi_q, nmi_d, ex;
    logic [15:0] amt;
    logic [15:0] view [16];
    logic        we [3];
    logic [3:0]  ws [3];
    logic [15:0] wv [3];

    function automatic logic [15:0] p16(input logic en, input logic [3:0] sel, input logic [3:0] code,
                                        input logic [15:0] v, input logic [15:0] cur);
        return (en && sel == code) ? v : cur;
    endfunction

    function automatic logic [7:0] p8(input logic en, input logic [3:0] sel, input logic [3:0] code,
                                      input logic [7:0] v, input logic [7:0] cur);
        return (en && sel == code) ? v : cur;
    endfunction

    always_comb begin
        view     = '{default: 16'hFFFF};
        view[0]  = {a_q, b_q};
        view[1]  = x_q;
        view[2]  = y_q;
        view[3]  = u_q;
        view[4]  = s_q;
        view[5]  = pc_q;
        view[8]  = {8'hFF, a_q};
        view[9]  = {8'hFF, b_q};
        view[10] = {8'hFF, cc_q};
        view[11] = {8'hFF, dp_q};
    end

    assign rda_out = view[rda_sel];
    assign rdb_out = view[rdb_sel];

    // Later writers in the list override earlier ones: write port, then exchange halves
    always_comb begin
        ex    = exg_en && exg_r0 != exg_r1;
        we[0] = wr_en;
        ws[0] = wr_sel;
        wv[0] = wr_data;
        we[1] = ex;
        ws[1] = exg_r1;
        wv[1] = view[exg_r0];
        we[2] = ex;
        ws[2] = exg_r0;
        wv[2] = view[exg_r1];
        amt   = idx_op[1] ? {15'h7FFF, ~idx_op[0]} : {14'h0, idx_op[0], ~idx_op[0]};
        x_d   = (idx_en && idx_sel == 2'd0) ? x_q + amt : x_q;
        y_d   = (idx_en && idx_sel == 2'd1) ? y_q + amt : y_q;
        u_d   = (idx_en && idx_sel == 2'd2) ? u_q + amt : u_q;
        s_d   = (idx_en && idx_sel == 2'd3) ? s_q + amt : s_q;
        pc_d  = pc_ld ? pc_in : pc_inc ? pc_q + 16'd1 : pc_q;
        cc_d  = ccr_we ? ccr_in : cc_q;
        a_d   = a_q;
        b_d   = b_q;
        dp_d  = dp_q;
        for (int k = 0; k < 3; k++) begin
            x_d  = p16(we[k], ws[k], 4'd1, wv[k], x_d);
            y_d  = p16(we[k], ws[k], 4'd2, wv[k], y_d);
            u_d  = p16(we[k], ws[k], 4'd3, wv[k], u_d);
            s_d  = p16(we[k], ws[k], 4'd4, wv[k], s_d);
            pc_d = p16(we[k], ws[k], 4'd5, wv[k], pc_d);
            a_d  = p8(we[k], ws[k], 4'd0, wv[k][15:8], p8(we[k], ws[k], 4'd8, wv[k][7:0], a_d));
            b_d  = p8(we[k], ws[k], 4'd0, wv[k][7:0], p8(we[k], ws[k], 4'd9, wv[k][7:0], b_d));
            cc_d = p8(we[k], ws[k], 4'd10, wv[k][7:0], cc_d);
            dp_d = p8(we[k], ws[k], 4'd11, wv[k][7:0], dp_d);
        end
        nmi_d = nmi_q | (wr_en && wr_sel == 4'd4) | (ex && (exg_r0 == 4'd4 || exg_r1 == 4'd4));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_q   <= 8'h00;
            b_q   <= 8'h00;
            dp_q  <= 8'h00;
            cc_q  <= 8'h50;
            x_q   <= 16'h0000;
            y_q   <= 16'h0000;
            u_q   <= 16'h0000;
            s_q   <= 16'h0000;
            pc_q  <= 16'h0000;
            nmi_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            dp_q  <= dp_d;
            cc_q  <= cc_d;
            x_q   <= x_d;
            y_q   <= y_d;
            u_q   <= u_d;
            s_q   <= s_d;
            pc_q  <= pc_d;
            nmi_q <= nmi_d;
        end
    end

    assign cc_out    = cc_q;
    assign dp_out    = dp_q;
    assign pc_out    = pc_q;
    assign s_out     = s_q;
    assign nmi_armed = nmi_q;
endmodule

// File: tb/tb_regfile_6809.sv
// tb_regfile_6809: directed table, corner sequences and randomized run against a register-array model
module tb_regfile_6809;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [3:0]  rda_sel, rdb_sel, wr_sel, exg_r0, exg_r1;
    logic [15:0] rda_out, rdb_out, wr_data, pc_in, pc_out, s_out;
    logic        wr_en, ccr_we, idx_en, pc_inc, pc_ld, exg_en, nmi_armed;
    logic [7:0]  ccr_in, cc_out, dp_out;
    logic [1:0]  idx_sel, idx_op;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m8 [4];
    logic [15:0] m16 [5];
    logic        mnmi;

    typedef struct {
        logic        we;
        logic [3:0]  ws;
        logic [15:0] wd;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [15:0] ea;
        logic [15:0] eb;
    } vec_t;
    vec_t tbl [8];

    regfile_6809 dut (
        .clk_in(clk_in), .rst_in(rst_in), .rda_sel(rda_sel), .rdb_sel(rdb_sel),
        .rda_out(rda_out), .rdb_out(rdb_out), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_data(wr_data), .ccr_we(ccr_we), .ccr_in(ccr_in), .idx_en(idx_en),
        .idx_sel(idx_sel), .idx_op(idx_op), .pc_inc(pc_inc), .pc_ld(pc_ld),
        .pc_in(pc_in), .exg_en(exg_en), .exg_r0(exg_r0), .exg_r1(exg_r1),
        .cc_out(cc_out), .dp_out(dp_out), .pc_out(pc_out), .s_out(s_out),
        .nmi_armed(nmi_armed)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [15:0] mread(input logic [3:0] c);
        if (c == 4'd0) return {m8[0], m8[1]};
        if (c >= 4'd1 && c <= 4'd5) return m16[3'(c - 4'd1)];
        if (c >= 4'd8 && c <= 4'd11) return {8'hFF, m8[2'(c - 4'd8)]};
        return 16'hFFFF;
    endfunction

    task automatic mwrite(input logic [3:0] c, input logic [15:0] v);
        if (c == 4'd0) begin
            m8[0] = v[15:8];
            m8[1] = v[7:0];
        end else if (c >= 4'd1 && c <= 4'd5) begin
            m16[3'(c - 4'd1)] = v;
        end else if (c >= 4'd8 && c <= 4'd11) begin
            m8[2'(c - 4'd8)] = v[7:0];
        end
        if (c == 4'd4) mnmi = 1'b1;
    endtask

    // Requests applied in rising priority: CC, index, PC, write port, exchange
    task automatic mstep();
        logic [15:0] to0, to1;
        logic        ex;
        int          delta;
        if (rst_in) begin
            m8   = '{8'h00, 8'h00, 8'h50, 8'h00};
            m16  = '{default: 16'h0000};
            mnmi = 1'b0;
        end else begin
            ex  = exg_en && exg_r0 != exg_r1;
            to0 = mread(exg_r1);
            to1 = mread(exg_r0);
            if (ccr_we) m8[2] = ccr_in;
            if (idx_en) begin
                delta = (idx_op == 2'd0) ? 1 : (idx_op == 2'd1) ? 2 : (idx_op == 2'd2) ? -1 : -2;
                m16[idx_sel] = m16[idx_sel] + 16'(delta);
            end
            if (pc_ld) m16[4] = pc_in;
            else if (pc_inc) m16[4] = m16[4] + 16'd1;
            if (wr_en) mwrite(wr_sel, wr_data);
            if (ex) begin
                mwrite(exg_r1, to1);
                mwrite(exg_r0, to0);
            end
        end
    endtask

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, act, exp);
        end
    endtask

    task automatic check_all();
        chk("cc", {8'h00, cc_out}, {8'h00, m8[2]});
        chk("dp", {8'h00, dp_out}, {8'h00, m8[3]});
        chk("pc", pc_out, m16[4]);
        chk("s", s_out, m16[3]);
        chk("nmi", {15'h0, nmi_armed}, {15'h0, mnmi});
        chk("rda", rda_out, mread(rda_sel));
        chk("rdb", rdb_out, mread(rdb_sel));
    endtask

    task automatic idle();
        wr_en = 0; wr_sel = 0; wr_data = 0; ccr_we = 0; ccr_in = 0;
        idx_en = 0; idx_sel = 0; idx_op = 0; pc_inc = 0; pc_ld = 0; pc_in = 0;
        exg_en = 0; exg_r0 = 0; exg_r1 = 0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        mstep();
        #1;
    endtask

    task automatic wr(input logic [3:0] sel, input logic [15:0] d);
        wr_en = 1; wr_sel = sel; wr_data = d;
    endtask

    initial begin
        tbl[0] = '{1, 4'd0,  16'h1234, 4'd8,  4'd9, 16'hFF12, 16'hFF34};
        tbl[1] = '{0, 4'd0,  16'h0000, 4'd0,  4'd1, 16'h1234, 16'h0000};
        tbl[2] = '{1, 4'd1,  16'hABCD, 4'd1,  4'd0, 16'hABCD, 16'h1234};
        tbl[3] = '{1, 4'd8,  16'h5577, 4'd0,  4'd8, 16'h7734, 16'hFF77};
        tbl[4] = '{1, 4'd10, 16'h00C3, 4'd10, 4'd6, 16'hFFC3, 16'hFFFF};
        tbl[5] = '{1, 4'd7,  16'h9999, 4'd7,  4'd1, 16'hFFFF, 16'hABCD};
        tbl[6] = '{1, 4'd11, 16'h1280, 4'd11, 4'd9, 16'hFF80, 16'hFF34};
        tbl[7] = '{1, 4'd5,  16'h4000, 4'd5,  4'd2, 16'h4000, 16'h0000};

        idle();
        rst_in = 1; rda_sel = 4'd8; rdb_sel = 4'd0;
        tick();
        rst_in = 0;
        chk("rst_cc", {8'h00, cc_out}, 16'h0050);
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_s", s_out, 16'h0000);
        chk("rst_nmi", {15'h0, nmi_armed}, 16'h0000);
        chk("rst_rda_a", rda_out, 16'hFF00);

        for (int i = 0; i < 8; i++) begin
            idle();
            wr_en = tbl[i].we; wr_sel = tbl[i].ws; wr_data = tbl[i].wd;
            rda_sel = tbl[i].ra; rdb_sel = tbl[i].rb;
            tick();
            chk($sformatf("tbl%0d_a", i), rda_out, tbl[i].ea);
            chk($sformatf("tbl%0d_b", i), rdb_out, tbl[i].eb);
        end

        idle(); rda_sel = 4'd1; wr(4'd1, 16'h0000); tick();
        idle(); idx_en = 1; idx_sel = 0; idx_op = 3; tick();
        chk("x_wrap_dec", rda_out, 16'hFFFE);
        idle(); wr(4'd1, 16'hFFFF); tick();
        idle(); idx_en = 1; idx_sel = 0; idx_op = 0; tick();
        chk("x_wrap_inc", rda_out, 16'h0000);
        idle(); wr(4'd1, 16'hAAAA); idx_en = 1; idx_sel = 0; idx_op = 0; tick();
        chk("x_collide", rda_out, 16'hAAAA);

        idle(); wr(4'd10, 16'h000F); ccr_we = 1; ccr_in = 8'hF0; tick();
        chk("cc_collide", {8'h00, cc_out}, 16'h000F);
        idle(); ccr_we = 1; ccr_in = 8'hA5; tick();
        chk("cc_load", {8'h00, cc_out}, 16'h00A5);

        idle(); pc_ld = 1; pc_inc = 1; pc_in = 16'hC000; tick();
        chk("pc_ld_prio", pc_out, 16'hC000);
        idle(); pc_inc = 1; tick();
        chk("pc_inc", pc_out, 16'hC001);
        idle(); pc_ld = 1; pc_in = 16'h1111; wr(4'd5, 16'h2222); tick();
        chk("pc_wr_prio", pc_out, 16'h2222);

        idle(); wr(4'd8, 16'h007F); tick();
        idle(); wr(4'd1, 16'h1234); tick();
        idle(); exg_en = 1; exg_r0 = 4'd8; exg_r1 = 4'd1; wr(4'd1, 16'h5555);
        rda_sel = 4'd8; rdb_sel = 4'd1; tick();
        chk("exg_a", rda_out, 16'hFF34);
        chk("exg_x", rdb_out, 16'hFF7F);
        idle(); exg_en = 1; exg_r0 = 4'd4; exg_r1 = 4'd4; tick();
        chk("exg_same_nmi", {15'h0, nmi_armed}, 16'h0000);

        idle(); idx_en = 1; idx_sel = 3; idx_op = 0; tick();
        chk("idx_s_noarm", {15'h0, nmi_armed}, 16'h0000);
        chk("idx_s_val", s_out, 16'h0001);
        idle(); wr(4'd4, 16'h8000); tick();
        chk("s_wr_arm", {15'h0, nmi_armed}, 16'h0001);
        chk("s_wr_val", s_out, 16'h8000);
        idle(); idx_en = 1; idx_sel = 3; idx_op = 1; tick();
        chk("nmi_hold", {15'h0, nmi_armed}, 16'h0001);
        chk("s_idx", s_out, 16'h8002);

        idle(); rst_in = 1; pc_ld = 1; pc_in = 16'hC000; wr(4'd4, 16'h1234); tick();
        rst_in = 0;
        chk("rst_mid_pc", pc_out, 16'h0000);
        chk("rst_mid_nmi", {15'h0, nmi_armed}, 16'h0000);
        chk("rst_mid_s", s_out, 16'h0000);
        chk("rst_mid_cc", {8'h00, cc_out}, 16'h0050);

        for (int i = 0; i < 600; i++) begin
            rst_in  = ($urandom_range(0, 59) == 0);
            wr_en   = 1'($urandom_range(0, 1));
            wr_sel  = 4'($urandom_range(0, 15));
            wr_data = 16'($urandom);
            ccr_we  = 1'($urandom_range(0, 1));
            ccr_in  = 8'($urandom);
            idx_en  = 1'($urandom_range(0, 1));
            idx_sel = 2'($urandom_range(0, 3));
            idx_op  = 2'($urandom_range(0, 3));
            pc_inc  = 1'($urandom_range(0, 1));
            pc_ld   = ($urandom_range(0, 3) == 0);
            pc_in   = 16'($urandom);
            exg_en  = ($urandom_range(0, 3) == 0);
            exg_r0  = 4'($urandom_range(0, 15));
            exg_r1  = 4'($urandom_range(0, 15));
            rda_sel = 4'($urandom_range(0, 15));
            rdb_sel = 4'($urandom_range(0, 15));
            tick();
            check_all();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
